// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache miss/fill path: fill FSM states, default
// block geometry and the width helpers used by the fill engine and cache arrays.
package cache_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } fill_state_t;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_WORDS      = 8;
    localparam int DEF_WORD_BYTES = 2;

    // Byte-offset bits inside one block.
    function automatic int off_w(input int words, input int word_bytes);
        return $clog2(words * word_bytes);
    endfunction

    function automatic int idx_w(input int words);
        return $clog2(words);
    endfunction

    // One extra bit so a counter can hold WORDS itself ("all done").
    function automatic int cnt_w(input int words);
        return $clog2(words) + 1;
    endfunction

    localparam int DEF_OFF_W = off_w(DEF_WORDS, DEF_WORD_BYTES);
    localparam int DEF_IDX_W = idx_w(DEF_WORDS);

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Saturating up-counter with synchronous clear, enable and terminal-count flag.
// Used for the request (tx) and return (rx) word counts of a block fill.
module fill_counter #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != W'(MAX))) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == W'(MAX));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss-handling engine: streams one block from pipelined memory into the
// data array, writes the tag with the last word, and stalls the pipeline meanwhile.
module cache_fill_fsm
    import cache_defs::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = 16,
    parameter int WORDS      = DEF_WORDS,
    parameter int WORD_BYTES = DEF_WORD_BYTES,
    parameter int MEM_LAT    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss_detected,
    input  logic [ADDR_W-1:0]        miss_address,
    output logic                     fsm_busy,
    output logic                     mem_en,
    output logic [ADDR_W-1:0]        memory_address,
    input  logic [DATA_W-1:0]        memory_data,
    input  logic                     memory_data_valid,
    output logic                     write_data_array,
    output logic [idx_w(WORDS)-1:0]  word_index,
    output logic [DATA_W-1:0]        fill_data,
    output logic                     write_tag_array,
    output fill_state_t              dbg_state
);

    localparam int OFF_W = off_w(WORDS, WORD_BYTES);
    localparam int IW    = idx_w(WORDS);
    localparam int CW    = cnt_w(WORDS);
    localparam int BSH   = $clog2(WORD_BYTES);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    if (WORDS < 2 || (WORDS & (WORDS - 1)) != 0 || (WORD_BYTES & (WORD_BYTES - 1)) != 0
        || MEM_LAT < 0) begin : g_param_check
        $error("cache_fill_fsm: WORDS/WORD_BYTES must be powers of 2 (WORDS>=2), MEM_LAT>=0");
    end

    fill_state_t       r_state;
    fill_state_t       w_state_nx;
    logic [ADDR_W-1:0] r_base;
    logic [CW-1:0]     w_tx;
    logic [CW-1:0]     w_rx;
    logic              w_tx_tc;
    logic              w_rx_tc;
    logic              w_start;
    logic              w_tx_en;
    logic              w_rx_ok;
    logic              w_last;

    // Memory returns are a one-way valid stream with no backpressure: every
    // cycle with memory_data_valid carries one word, in request order.
    assign w_rx_ok = (r_state != IDLE) && memory_data_valid && !w_rx_tc;
    assign w_last  = w_rx_ok && (w_rx == CW'(WORDS - 1));

    fill_counter #(.W(CW), .MAX(WORDS)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_start),
        .i_en    (w_tx_en),
        .o_count (w_tx),
        .o_tc    (w_tx_tc)
    );

    fill_counter #(.W(CW), .MAX(WORDS)) u_rx (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_start),
        .i_en    (w_rx_ok),
        .o_count (w_rx),
        .o_tc    (w_rx_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_base  <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_start) begin
                r_base <= miss_address & ~OFF_MASK;
            end
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_start        = 1'b0;
        w_tx_en        = 1'b0;
        mem_en         = 1'b0;
        memory_address = '0;
        case (r_state)
            IDLE: begin
                if (miss_detected) begin
                    w_start    = 1'b1;
                    w_state_nx = FILL;
                end
            end
            FILL: begin
                mem_en         = !w_tx_tc;
                w_tx_en        = !w_tx_tc;
                memory_address = r_base + (ADDR_W'(w_tx) << BSH);
                // Completion wins even if the last word lands before issuing ends.
                if (w_last) begin
                    w_state_nx = IDLE;
                end else if (w_tx == CW'(WORDS - 1)) begin
                    w_state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (w_last) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign fsm_busy         = (r_state != IDLE) || ((r_state == IDLE) && miss_detected);
    assign write_data_array = w_rx_ok;
    assign word_index       = w_rx[IW-1:0];
    assign fill_data        = w_rx_ok ? memory_data : '0;
    assign write_tag_array  = w_last;
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomised bench for cache_fill_fsm: a pipelined memory responder plus a
// block-level reference model of the fill, exercised on two geometries.
module tb_cache_fill_fsm;
    import cache_defs::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, miss, mvalid, sel;
    logic [31:0] maddr, mdata;

    logic        a_busy, a_en, a_wr, a_tag;
    logic [15:0] a_addr, a_fdata;
    logic [2:0]  a_idx;
    fill_state_t a_st;
    logic        b_busy, b_en, b_wr, b_tag;
    logic [31:0] b_addr, b_fdata;
    logic [1:0]  b_idx;
    fill_state_t b_st;

    cache_fill_fsm #(.DATA_W(16), .ADDR_W(16), .WORDS(8), .WORD_BYTES(2), .MEM_LAT(4)) dut_a (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss & ~sel),
        .miss_address      (maddr[15:0]),
        .fsm_busy          (a_busy),
        .mem_en            (a_en),
        .memory_address    (a_addr),
        .memory_data       (mdata[15:0]),
        .memory_data_valid (mvalid & ~sel),
        .write_data_array  (a_wr),
        .word_index        (a_idx),
        .fill_data         (a_fdata),
        .write_tag_array   (a_tag),
        .dbg_state         (a_st)
    );

    cache_fill_fsm #(.DATA_W(32), .ADDR_W(32), .WORDS(4), .WORD_BYTES(4), .MEM_LAT(1)) dut_b (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss & sel),
        .miss_address      (maddr),
        .fsm_busy          (b_busy),
        .mem_en            (b_en),
        .memory_address    (b_addr),
        .memory_data       (mdata),
        .memory_data_valid (mvalid & sel),
        .write_data_array  (b_wr),
        .word_index        (b_idx),
        .fill_data         (b_fdata),
        .write_tag_array   (b_tag),
        .dbg_state         (b_st)
    );

    logic        o_busy, o_en, o_wr, o_tag;
    logic [31:0] o_addr, o_fdata, o_idx;
    assign o_busy  = sel ? b_busy : a_busy;
    assign o_en    = sel ? b_en : a_en;
    assign o_wr    = sel ? b_wr : a_wr;
    assign o_tag   = sel ? b_tag : a_tag;
    assign o_addr  = sel ? b_addr : {16'h0, a_addr};
    assign o_fdata = sel ? b_fdata : {16'h0, a_fdata};
    assign o_idx   = sel ? {30'h0, b_idx} : {29'h0, a_idx};

    int          checks = 0, failures = 0, cyc = 0;
    int          words = 8, wb = 2, lat = 4;
    logic [31:0] dmask = 32'hFFFF, amask = 32'hFFFF;

    int          due_q[$];
    logic [31:0] ret_q[$];
    logic [31:0] exp_q[$];

    bit          m_active = 0;
    logic [31:0] m_base = 0;
    int          m_issued = 0, m_recv = 0;

    int          miss_cyc = 0, tag_cyc = 0, lo_cyc = 0;
    int          n_req = 0, n_wr = 0, n_tag = 0, n_wr_post = 0;
    logic [31:0] first_addr = 0, last_addr = 0;
    bit          lo_seen = 0, post_rst = 0;

    int          stall = 0, bubble_at = 0, bubble_len = 0;
    bit          bub_done = 0, stray_req = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_mem();
        int d;
        if (!bub_done && bubble_len > 0 && stall == 0 && m_active && m_recv == bubble_at
            && due_q.size() > 0 && due_q[0] <= cyc) begin
            stall    = bubble_len;
            bub_done = 1;
        end
        if (stall > 0) begin
            stall--;
            mvalid = 1'b0;
            mdata  = '0;
        end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
            d      = due_q.pop_front();
            mdata  = mem_fn(ret_q.pop_front());
            mvalid = 1'b1;
        end else if (stray_req) begin
            mvalid    = 1'b1;
            mdata     = $urandom;
            stray_req = 0;
        end else begin
            mvalid = 1'b0;
            mdata  = '0;
        end
    endtask

    task automatic monitor();
        bit          e_en, e_wr, e_tag, e_busy;
        logic [31:0] e_addr, e_data;
        if (rst) begin
            m_active = 0;
            exp_q.delete();
            post_rst = 1;
        end
        e_busy = m_active || miss;
        e_en   = m_active && (m_issued < words);
        e_addr = e_en ? m_base + 32'(m_issued * wb) : 32'h0;
        e_wr   = m_active && mvalid && (m_recv < words);
        e_tag  = e_wr && (m_recv == words - 1);
        check_eq("fsm_busy", o_busy, e_busy);
        check_eq("mem_en", o_en, e_en);
        check_eq("memory_address", o_addr, e_addr);
        check_eq("write_data_array", o_wr, e_wr);
        check_eq("write_tag_array", o_tag, e_tag);
        if (e_wr) begin
            e_data = 32'hDEADBEEF;
            if (exp_q.size() > 0) e_data = exp_q.pop_front();
            check_eq("word_index", o_idx, m_recv);
            check_eq("fill_data", o_fdata, e_data);
        end
        if (o_en) begin
            due_q.push_back(cyc + lat);
            ret_q.push_back(o_addr);
            if (n_req == 0) first_addr = o_addr;
            last_addr = o_addr;
            n_req++;
        end
        if (e_en) exp_q.push_back(mem_fn(e_addr) & dmask);
        if (o_wr) begin
            n_wr++;
            if (post_rst) n_wr_post++;
        end
        if (o_tag) begin
            n_tag++;
            tag_cyc = cyc;
        end
        if (!o_busy && !lo_seen) begin
            lo_seen = 1;
            lo_cyc  = cyc;
        end
        if (!rst && !m_active && miss) begin
            m_active = 1;
            m_base   = maddr & ~32'(words * wb - 1);
            m_issued = 0;
            m_recv   = 0;
            exp_q.delete();
            miss_cyc = cyc;
            n_req = 0; n_wr = 0; n_tag = 0; n_wr_post = 0;
            lo_seen  = 0;
            post_rst = 0;
        end else if (!rst && m_active) begin
            if (e_en) m_issued++;
            if (e_wr) m_recv++;
            if (e_tag) m_active = 0;
        end
    endtask

    task automatic cycle();
        drive_mem();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_fill(input bit s, input logic [31:0] addr, input int l, input int b_at,
                            input int b_len, input bit noise, input int abort);
        bit done = 0, x9 = 0;
        sel        = s;
        lat        = l;
        words      = s ? 4 : 8;
        wb         = s ? 4 : 2;
        dmask      = s ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        amask      = dmask;
        bubble_at  = b_at;
        bubble_len = b_len;
        bub_done   = 0;
        stall      = 0;
        miss       = 1'b1;
        maddr      = addr & amask;
        for (int n = 0; n < 200 && !done; n++) begin
            if (n > 0) begin
                if (noise && m_active && m_issued < words) begin
                    miss  = 1'($urandom_range(0, 1));
                    maddr = $urandom & amask;
                end else begin
                    miss = 1'b0;
                end
                if (!m_active && !x9 && !rst) begin
                    stray_req = 1;
                    x9        = 1;
                end
            end
            if (abort > 0 && n == abort) rst = 1'b1;
            if (abort > 0 && n == abort + 2) rst = 1'b0;
            cycle();
            if (n > 0 && !rst && !m_active && due_q.size() == 0 && lo_seen && !stray_req) done = 1;
        end
        check_eq("fill_completes", done, 1);
    endtask

    task automatic idle(input int k);
        miss = 1'b0;
        for (int i = 0; i < k; i++) begin
            stray_req = 1'($urandom_range(0, 1));
            cycle();
        end
        stray_req = 0;
    endtask

    initial begin
        rst = 1'b1; miss = 1'b0; maddr = '0; mvalid = 1'b0; mdata = '0; sel = 1'b0;
        #1;
        cycle();
        check_eq("reset_busy", o_busy, 0);
        check_eq("reset_mem_en", o_en, 0);
        check_eq("reset_tag", o_tag, 0);
        miss = 1'b1;
        cycle();
        check_eq("reset_busy_follows_miss", o_busy, 1);
        miss = 1'b0;
        rst  = 1'b0;
        idle(3);

        run_fill(0, 32'h1236, 4, 0, 0, 0, 0);
        check_eq("basic_first_req", first_addr, 32'h1230);
        check_eq("basic_last_req", last_addr, 32'h123E);
        check_eq("basic_n_req", n_req, 8);
        check_eq("basic_n_wr", n_wr, 8);
        check_eq("basic_n_tag", n_tag, 1);
        check_eq("basic_tag_cycle", tag_cyc - miss_cyc, 12);
        check_eq("basic_busy_low_cycle", lo_cyc - miss_cyc, 13);
        idle(4);

        run_fill(0, 32'h2000, 4, 3, 3, 0, 0);
        check_eq("bubble_n_wr", n_wr, 8);
        check_eq("bubble_n_tag", n_tag, 1);
        check_eq("bubble_tag_cycle", tag_cyc - miss_cyc, 15);
        check_eq("bubble_busy_low_cycle", lo_cyc - miss_cyc, 16);
        idle(2);

        run_fill(0, 32'hFFFF, 4, 0, 0, 0, 0);
        check_eq("top_first_req", first_addr, 32'hFFF0);
        check_eq("top_last_req", last_addr, 32'hFFFE);
        check_eq("top_n_req", n_req, 8);
        idle(2);

        run_fill(0, 32'h1236, 4, 0, 0, 0, 6);
        check_eq("abort_n_tag", n_tag, 0);
        check_eq("abort_writes_after_reset", n_wr_post, 0);
        idle(2);
        run_fill(0, 32'h0040, 4, 0, 0, 0, 0);
        check_eq("post_abort_first_req", first_addr, 32'h0040);
        check_eq("post_abort_n_tag", n_tag, 1);
        check_eq("post_abort_tag_cycle", tag_cyc - miss_cyc, 12);
        idle(2);

        run_fill(0, 32'h3456, 3, 0, 0, 1, 0);
        check_eq("noise_first_req", first_addr, 32'h3450);
        check_eq("noise_last_req", last_addr, 32'h345E);
        check_eq("noise_n_wr", n_wr, 8);
        check_eq("noise_n_tag", n_tag, 1);
        idle(8);

        run_fill(1, 32'h0000_0104, 1, 0, 0, 0, 0);
        check_eq("sweep_first_req", first_addr, 32'h100);
        check_eq("sweep_last_req", last_addr, 32'h10C);
        check_eq("sweep_n_req", n_req, 4);
        check_eq("sweep_tag_cycle", tag_cyc - miss_cyc, 5);
        check_eq("sweep_busy_low_cycle", lo_cyc - miss_cyc, 6);
        idle(2);

        for (int t = 0; t < 16; t++) begin
            bit s;
            int l, bl, ba;
            s  = 1'($urandom_range(0, 1));
            l  = $urandom_range(1, 6);
            bl = $urandom_range(0, 3);
            ba = $urandom_range(0, s ? 3 : 7);
            run_fill(s, $urandom, l, ba, bl, 1, 0);
            check_eq("rand_n_wr", n_wr, words);
            check_eq("rand_n_tag", n_tag, 1);
            check_eq("rand_tag_cycle", tag_cyc - miss_cyc, words + l + (bub_done ? bl : 0));
            idle($urandom_range(1, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling engine for the next-generation CPU's instruction and data caches. There is one instance per cache.
- On a miss it fetches a whole block from a pipelined, multi-cycle main memory, one word request per cycle.
- It writes each returned word into the cache data array, then writes the tag when the last word lands.
- It holds the pipeline stall (fsm_busy) for the whole fill. Width, block size and memory latency are parametrised.

Parameters:
- DATA_W, 16: memory/cache word width in bits.
- ADDR_W, 16: byte-address width.
- WORDS, 8: words per cache block. Must be a power of 2, at least 2.
- WORD_BYTES, 2: bytes per word. Must be a power of 2.
- MEM_LAT, 4: nominal memory read latency in cycles. Used only for documentation and bench checks; the RTL relies on memory_data_valid.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- miss_detected, in, 1: cache miss this cycle.
- miss_address, in, ADDR_W: byte address of the missing access.
- fsm_busy, out, 1: stall to the pipeline.
- mem_en, out, 1: memory read request this cycle.
- memory_address, out, ADDR_W: request address.
- memory_data, in, DATA_W: returned read data.
- memory_data_valid, in, 1: memory_data is valid this cycle.
- write_data_array, out, 1: write fill_data into the data array at word_index.
- word_index, out, $clog2(WORDS): word offset within the block for the data-array write.
- fill_data, out, DATA_W: copy of memory_data.
- write_tag_array, out, 1: single-cycle pulse to write the tag and valid bit for the latched block.

Behaviour:
- OFF_W = $clog2(WORDS*WORD_BYTES).
- base = latched miss_address with its low OFF_W bits cleared. The block is aligned, so addresses never wrap past the block or past the address space.
- Registers:
  - state: IDLE / FILL / DRAIN.
  - base address.
  - issue count tx and receive count rx, each $clog2(WORDS)+1 bits.
- Reset (asynchronous, any time including mid-fill):
  - state=IDLE, tx=rx=0, base=0.
  - All outputs 0, except that fsm_busy follows its combinational equation with state=IDLE.
  - No tag write on an aborted fill. Memory returns arriving after reset are ignored.
- fsm_busy = (state!=IDLE) | (state==IDLE & miss_detected). It is combinational, so the pipeline stalls in the miss cycle.
- IDLE:
  - On miss_detected, latch base, clear tx/rx, go to FILL next cycle. No request is issued in this cycle.
  - memory_data_valid is ignored in IDLE.
- FILL:
  - mem_en=1 and memory_address = base + tx*WORD_BYTES, with tx incrementing every cycle.
  - When tx reaches WORDS-1 this cycle, go to DRAIN.
- DRAIN: mem_en=0. Receiving continues.
- Receiving, in FILL or DRAIN, is independent of issuing, so MEM_LAT < WORDS overlaps correctly:
  - Each cycle with memory_data_valid and rx<WORDS: write_data_array=1, word_index=rx[low bits], fill_data=memory_data, then rx increments.
  - Valid pulses beyond WORDS are ignored.
- Completion: on the cycle rx reaches WORDS-1 with valid, write_tag_array=1 (same cycle as the last data write), and state goes to IDLE next cycle.
  - If the last return arrives while still in FILL (degenerate latency), the same completion rule applies.
- Changes on miss_address or miss_detected during FILL/DRAIN are ignored.
- If miss_detected is still high in the first IDLE cycle after completion, a new fill starts. Callers deassert it once the tag hits.
- Timing, with the miss seen in cycle 0:
  - Requests in cycles 1..WORDS.
  - Data nominally in cycles 1+MEM_LAT .. WORDS+MEM_LAT.
  - Tag pulse in cycle WORDS+MEM_LAT.
  - fsm_busy low from cycle WORDS+MEM_LAT+1.
  - Total stall = WORDS+MEM_LAT+1 cycles.
- Gaps in memory_data_valid lengthen DRAIN without error. There is no timeout.

Decomposition:
- Shared package cache_defs holds:
  - the fill_state_t enum (IDLE, FILL, DRAIN);
  - the OFF_W and index-width helper constants;
  - defaults for WORDS, WORD_BYTES and DATA_W, shared with the cache arrays and the memory model.
- One natural sub-module, fill_counter: a parametrised saturating up-counter with clear, enable and terminal-count output, instantiated twice (tx, rx).

Test Plan:
- Basic fill: miss at 0x1236 with defaults and latency 4.
  - Requests 0x1230,0x1232..0x123E in cycles 1-8.
  - Data writes at word_index 0..7 in cycles 5-12.
  - write_tag_array only in cycle 12; fsm_busy high in cycles 0-12, low in cycle 13.
- Bubbled returns: valid deasserted for 3 cycles mid-stream.
  - Exactly 8 data writes in order and a single tag pulse on the 8th.
  - Busy extends by 3 cycles.
- Address alignment at top of memory: miss at 0xFFFF.
  - Requests 0xFFF0..0xFFFE with no wrap to 0x0000.
- Reset mid-fill: assert rst in cycle 6.
  - Outputs clear immediately and no tag write.
  - Later valid pulses produce no data writes.
  - A new miss at 0x0040 completes normally.
- Noise and extras:
  - miss_address change and miss_detected toggle during the fill do not alter addresses.
  - Stray valid in IDLE and a 9th valid after completion produce no writes.
- Parameter sweep: WORDS=4, DATA_W=32, WORD_BYTES=4, latency 1.
  - Miss at 0x0000_0104 issues requests 0x100..0x10C.
  - Tag pulse in cycle 5; busy low in cycle 6.
